// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the accumulator CPU:
// memory geometry, opcode constants and the loader state encoding.
package program_loader_pkg;

  localparam int DEPTH   = 10;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 12;
  localparam int NIB_W   = 4;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] HALT_OP = 4'hA;

  // CPU opcodes carried in word[11:8]; the operand is word[7:0]
  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OPC_W-1:0] OP_HALT = HALT_OP;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/program_loader_nibble_assembler.sv
// Packs accepted nibbles MSN-first into an instruction word and keeps a
// running XOR checksum; word_ready marks the accept that completes a word.
module program_loader_nibble_assembler #(
  parameter int INSTR_W = 12,
  parameter int NIB_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [NIB_W-1:0]   i_nib,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_word_ready,
  output logic [NIB_W-1:0]   o_checksum
);

  localparam int NIBS     = INSTR_W / NIB_W;
  localparam int IDX_W    = $clog2(NIBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  logic [IDX_W-1:0]   r_idx;
  logic [INSTR_W-1:0] r_word;
  logic [NIB_W-1:0]   r_sum;

  assign o_word_ready = i_accept && (r_idx == LAST_IDX);
  assign o_word       = r_word;
  assign o_checksum   = r_sum;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain the shift register within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_word <= '0;
      r_sum  <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
      r_sum  <= '0;
    end else if (i_accept) begin
      r_word <= {r_word[INSTR_W-NIB_W-1:0], i_nib};
      r_sum  <= r_sum ^ i_nib;
      r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a nibble-streamed program into the CPU instruction memory, verifies a
// trailing XOR checksum and pulses cpu_rst so the CPU starts from PC=0.
module program_loader #(
  parameter int               DEPTH   = program_loader_pkg::DEPTH,
  parameter int               ADDR_W  = program_loader_pkg::ADDR_W,
  parameter int               INSTR_W = program_loader_pkg::INSTR_W,
  parameter logic [3:0]       HALT_OP = program_loader_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         nib_in,
  input  logic               nib_valid,
  output logic               nib_ready,
  output logic               we,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  words_loaded
);

  import program_loader_pkg::state_t;
  import program_loader_pkg::IDLE;
  import program_loader_pkg::RECV;
  import program_loader_pkg::WRITE;
  import program_loader_pkg::CHECK;
  import program_loader_pkg::RELEASE;
  import program_loader_pkg::DONE;
  import program_loader_pkg::ERROR;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_words;
  logic                w_take;
  logic                w_start_session;
  logic                w_asm_accept;
  logic                w_word_ready;
  logic                w_last_word;
  logic [INSTR_W-1:0]  w_word;
  logic [3:0]          w_checksum;

  assign w_take          = nib_valid && nib_ready;
  assign w_start_session = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_asm_accept    = w_take && (r_state == RECV);
  assign w_last_word     = (r_addr == LAST_ADDR) || (w_word[INSTR_W-1 -: 4] == HALT_OP);

  program_loader_nibble_assembler #(
    .INSTR_W (INSTR_W),
    .NIB_W   (4)
  ) u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start_session),
    .i_accept     (w_asm_accept),
    .i_nib        (nib_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready),
    .o_checksum   (w_checksum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE, ERROR: if (w_start_session) w_next = RECV;
      RECV:              if (w_word_ready)    w_next = WRITE;
      WRITE:             w_next = w_last_word ? CHECK : RECV;
      CHECK:             if (w_take) w_next = (nib_in == w_checksum) ? RELEASE : ERROR;
      RELEASE:           w_next = DONE;
      default:           w_next = IDLE;
    endcase
  end

  // Moore decode: no input reaches these outputs, so cpu_rst and we can never overlap
  always_comb begin
    nib_ready = 1'b0;
    we        = 1'b0;
    cpu_rst   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      RECV:    begin nib_ready = 1'b1; busy = 1'b1; end
      WRITE:   begin we        = 1'b1; busy = 1'b1; end
      CHECK:   begin nib_ready = 1'b1; busy = 1'b1; end
      RELEASE: begin cpu_rst   = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      ERROR:   err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_words <= '0;
    end else if (w_start_session) begin
      r_addr  <= '0;
      r_words <= '0;
    end else if (r_state == WRITE) begin
      r_words <= r_words + 1'b1;
      if (!w_last_word) r_addr <= r_addr + 1'b1;
    end
  end

  assign instr_addr   = r_addr;
  assign instr_out    = w_word;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad checksum, full memory, gaps,
// mid-load reset and start while busy, checked with immediate assertions.
module tb_program_loader;
  import program_loader_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [3:0]         nib_in;
  logic               nib_valid;
  logic               nib_ready;
  logic               we;
  logic [ADDR_W-1:0]  instr_addr;
  logic [INSTR_W-1:0] instr_out;
  logic               cpu_rst;
  logic               busy;
  logic               done;
  logic               err;
  logic [ADDR_W-1:0]  words_loaded;

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .nib_in       (nib_in),
    .nib_valid    (nib_valid),
    .nib_ready    (nib_ready),
    .we           (we),
    .instr_addr   (instr_addr),
    .instr_out    (instr_out),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Write log and protocol observations, sampled mid-cycle
  int                 n_wr   = 0;
  int                 n_rst  = 0;
  int                 n_viol = 0;
  logic [ADDR_W-1:0]  wr_addr [64];
  logic [INSTR_W-1:0] wr_data [64];

  always @(negedge clk) begin
    if (we && n_wr < 64) begin
      wr_addr[n_wr] <= instr_addr;
      wr_data[n_wr] <= instr_out;
    end
    if (we) n_wr <= n_wr + 1;
    if (cpu_rst) n_rst <= n_rst + 1;
    if (((we || cpu_rst) && nib_ready) || (we && cpu_rst)) n_viol <= n_viol + 1;
  end

  logic [3:0] q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams q; gap_max=0 keeps nib_valid high throughout, inject>=0 pulses start after that nibble
  task automatic run_stream(input int gap_max, input int inject);
    for (int i = 0; i < q.size(); i++) begin
      int t;
      int g;
      nib_in    = q[i];
      nib_valid = 1'b1;
      t = 0;
      while (!nib_ready && t < 64) begin
        @(negedge clk);
        t++;
      end
      if (t >= 64) check("nib_ready_wait", {31'b0, nib_ready}, 32'd1);
      @(negedge clk);
      if (i == inject) begin
        nib_valid = 1'b0;
        do_start();
      end
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (g > 0) begin
        nib_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    nib_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || err) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("session_end_timeout", {31'b0, done | err}, 32'd1);
  endtask

  task automatic load_prog1(input logic [3:0] csum);
    q = '{4'h1, 4'h0, 4'h5, 4'h2, 4'h0, 4'h3, 4'hA, 4'h0, 4'h0, csum};
  endtask

  task automatic check_prog1(input string tag, input int base, input int r0, input int v0);
    check({tag, "_nwr"},   n_wr - base,              32'd3);
    check({tag, "_a0"},    wr_addr[base],            32'd0);
    check({tag, "_d0"},    wr_data[base],            32'h105);
    check({tag, "_a1"},    wr_addr[base + 1],        32'd1);
    check({tag, "_d1"},    wr_data[base + 1],        32'h203);
    check({tag, "_a2"},    wr_addr[base + 2],        32'd2);
    check({tag, "_d2"},    wr_data[base + 2],        32'hA00);
    check({tag, "_rst"},   n_rst - r0,               32'd1);
    check({tag, "_done"},  {31'b0, done},            32'd1);
    check({tag, "_err"},   {31'b0, err},             32'd0);
    check({tag, "_busy"},  {31'b0, busy},            32'd0);
    check({tag, "_words"}, {28'b0, words_loaded},    32'd3);
    check({tag, "_viol"},  n_viol - v0,              32'd0);
  endtask

  initial begin
    int base;
    int r0;
    int v0;

    reset     = 1'b1;
    start     = 1'b0;
    nib_valid = 1'b0;
    nib_in    = 4'h0;
    #3;
    check("rst_state", {we, cpu_rst, nib_ready, busy, done, err}, 32'd0);
    check("rst_addr",  {instr_out, instr_addr, words_loaded},     32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, nib_ready}, 32'd0);

    // Basic load with early HALT, nib_valid held high across WRITE/RELEASE
    base = n_wr; r0 = n_rst; v0 = n_viol;
    do_start();
    check("t1_busy",  {31'b0, busy},         32'd1);
    check("t1_words", {28'b0, words_loaded}, 32'd0);
    load_prog1(4'hF);
    run_stream(0, -1);
    wait_end();
    check_prog1("t1", base, r0, v0);

    // Full memory of ADD 1, checksum 0
    base = n_wr; r0 = n_rst; v0 = n_viol;
    do_start();
    check("t2_done_clr", {31'b0, done}, 32'd0);
    q.delete();
    for (int k = 0; k < 10; k++) begin
      q.push_back(4'h2); q.push_back(4'h0); q.push_back(4'h1);
    end
    q.push_back(4'h0);
    run_stream(0, -1);
    wait_end();
    check("t2_nwr",   n_wr - base,           32'd10);
    check("t2_a4",    wr_addr[base + 4],     32'd4);
    check("t2_a9",    wr_addr[base + 9],     32'd9);
    check("t2_d9",    wr_data[base + 9],     32'h201);
    check("t2_done",  {31'b0, done},         32'd1);
    check("t2_words", {28'b0, words_loaded}, 32'd10);
    check("t2_rst",   n_rst - r0,            32'd1);
    check("t2_viol",  n_viol - v0,           32'd0);

    // Bad checksum, then a clean reload
    base = n_wr; r0 = n_rst;
    do_start();
    load_prog1(4'hE);
    run_stream(0, -1);
    wait_end();
    check("t3_err",  {31'b0, err},  32'd1);
    check("t3_done", {31'b0, done}, 32'd0);
    check("t3_busy", {31'b0, busy}, 32'd0);
    check("t3_rst",  n_rst - r0,    32'd0);
    check("t3_nwr",  n_wr - base,   32'd3);
    base = n_wr; r0 = n_rst; v0 = n_viol;
    do_start();
    check("t3_err_clr", {31'b0, err}, 32'd0);
    load_prog1(4'hF);
    run_stream(0, -1);
    wait_end();
    check_prog1("t3r", base, r0, v0);

    // Random idle gaps on nib_valid
    base = n_wr; r0 = n_rst; v0 = n_viol;
    do_start();
    load_prog1(4'hF);
    run_stream(3, -1);
    wait_end();
    check_prog1("t4", base, r0, v0);

    // Reset after 4 nibbles, with start held alongside reset
    do_start();
    q = '{4'h1, 4'h0, 4'h5, 4'h2};
    run_stream(0, -1);
    reset = 1'b1;
    start = 1'b1;
    #1;
    check("t5_ctl",  {we, cpu_rst, nib_ready, busy, done, err}, 32'd0);
    check("t5_data", {instr_out, instr_addr, words_loaded},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("t5_idle_busy", {31'b0, busy}, 32'd0);
    base = n_wr; r0 = n_rst; v0 = n_viol;
    do_start();
    load_prog1(4'hF);
    run_stream(0, -1);
    wait_end();
    check_prog1("t5", base, r0, v0);

    // start pulsed mid-session after the second word
    base = n_wr; r0 = n_rst; v0 = n_viol;
    do_start();
    load_prog1(4'hF);
    run_stream(0, 5);
    wait_end();
    check_prog1("t6", base, r0, v0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the accumulator CPU's instruction-memory load port. Drives the CPU's we / instr_addr / instr_in.
- Receives a program as a stream of 4-bit nibbles over a valid/ready handshake, three nibbles per word, most-significant nibble first.
- Writes each assembled 12-bit word to consecutive addresses starting at 0, then checks a trailing XOR checksum nibble.
- On a checksum match, pulses a CPU reset so execution starts at PC=0.

Parameters:
- DEPTH, 10, number of instruction-memory words in the CPU.
- ADDR_W, 4, address width.
- INSTR_W, 12, instruction width (4-bit opcode + 8-bit operand).
- HALT_OP, 4'hA, opcode that ends a program early.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a load session (single-cycle pulse)
- nib_in  input  4  program/checksum nibble
- nib_valid  input  1  nib_in is valid
- nib_ready  output  1  loader accepts a nibble this cycle
- we  output  1  write strobe to the CPU
- instr_addr  output  ADDR_W  write address to the CPU
- instr_out  output  INSTR_W  write data to the CPU (CPU instr_in)
- cpu_rst  output  1  one-cycle CPU reset pulse after a good load
- busy  output  1  session in progress
- done  output  1  last session loaded and verified (sticky)
- err  output  1  last session failed its checksum (sticky)
- words_loaded  output  ADDR_W  number of words written in the current/last session

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs 0: we, instr_addr, instr_out, cpu_rst, nib_ready, busy, done, err, words_loaded. Internal nibble index and checksum are cleared.
- Reset mid-session aborts the session. CPU memory keeps whatever was already written; no recovery is attempted.
- Transfer rule: a nibble is accepted when nib_valid && nib_ready at a rising clock edge. nib_ready is a registered function of state: 1 in RECV and CHECK, 0 in every other state.
- States:
  - IDLE: start → RECV. The same transition applies from DONE and ERROR. Entering RECV clears instr_addr, words_loaded, checksum, nibble index, done and err, and sets busy=1.
  - RECV: accept nibbles into word bits [11:8], then [7:4], then [3:0]. Every accepted nibble is XORed into a 4-bit running checksum. The edge that accepts the third nibble moves to WRITE.
  - WRITE: exactly one cycle. we=1, with instr_addr and instr_out stable for the whole cycle and nib_ready=0. we rises the cycle after the third nibble is accepted. words_loaded increments on exit. Exit: if instr_addr==DEPTH-1 or word[11:8]==HALT_OP → CHECK; otherwise instr_addr+1 → RECV.
  - CHECK: accept one nibble. If it equals the running checksum → RELEASE; otherwise → ERROR (err=1, busy=0, no cpu_rst).
  - RELEASE: cpu_rst=1 for exactly one cycle, then DONE (done=1, busy=0).
  - DONE / ERROR: hold until start.
- start while busy is ignored.
- start and reset asserted together: reset wins.
- An address never exceeds DEPTH-1, so there is no wrap-around.
- cpu_rst is never asserted while we=1, because the CPU ignores we while held in reset.
- nib_valid gaps are allowed at any point; partial word and checksum state hold until the next transfer.

Decomposition:
- Shared package: state encoding (IDLE, RECV, WRITE, CHECK, RELEASE, DONE, ERROR), HALT_OP, DEPTH, INSTR_W, and the CPU opcode constants. The CPU and its bench reuse this package.
- Optional sub-module: nibble_assembler (3-nibble shift register + index counter + XOR checksum, with an accept-in and word_ready-out handshake). The FSM stays in program_loader.

Test Plan:
- Basic load with early HALT:
  - Stimulus: start, then nibbles 1,0,5, 2,0,3, A,0,0, checksum F.
  - Response: we pulses at addr 0/1/2 with 0x105/0x203/0xA00, then a one-cycle cpu_rst, done=1, words_loaded=3.
  - With the CPU attached, AC=8 after execution.
- Full memory, no HALT:
  - Stimulus: ten words 2,0,1 (ADD 1), checksum 0.
  - Response: last write at addr 9, then CHECK; done=1, words_loaded=10.
- Bad checksum:
  - Stimulus: the first program with E instead of F.
  - Response: err=1, done=0, cpu_rst never asserted. A following start clears err and reloads correctly.
- Backpressure and gaps:
  - Stimulus: nib_valid held high continuously, plus random idle gaps.
  - Response: no nibble accepted during WRITE/RELEASE. Same addresses, data and checksum as the basic load.
- Reset mid-load:
  - Stimulus: assert reset after 4 nibbles.
  - Response: all outputs 0 immediately, nib_ready=0. A later start reloads from addr 0.
- start during a session:
  - Stimulus: pulse start after the 2nd word.
  - Response: ignored; the session completes unchanged with words_loaded correct.
